// File: rtl/reservation_station_pkg.sv
// Shared widths, entry/operand payload types and the wakeup snoop helper for the ALU reservation station.
package reservation_station_pkg;

    localparam int unsigned RS_SIZE   = 16;
    localparam int unsigned RS_ID_W   = $clog2(RS_SIZE);
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned ROB_POS_W = 4;
    localparam int unsigned OPCODE_W  = 7;
    localparam int unsigned FUNCT3_W  = 3;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ARITH  = 7'b0110011,
        OP_ARITHI = 7'b0010011,
        OP_BR     = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111
    } opcode_e;

    typedef struct packed {
        logic                 rdy;
        logic [DATA_W-1:0]    val;
        logic [ROB_POS_W-1:0] rob;
    } operand_t;

    typedef struct packed {
        logic                 busy;
        logic [OPCODE_W-1:0]  opcode;
        logic [FUNCT3_W-1:0]  funct3;
        logic                 funct7;
        operand_t             op1;
        operand_t             op2;
        logic [DATA_W-1:0]    imm;
        logic [ADDR_W-1:0]    pc;
        logic [ROB_POS_W-1:0] rob_pos;
    } rs_entry_t;

    typedef struct packed {
        logic                 en;
        logic [ROB_POS_W-1:0] rob_pos;
        logic [DATA_W-1:0]    val;
    } cdb_t;

    // Capture a broadcast value for a waiting operand; the ALU bus wins a (never legal) tag tie.
    function automatic operand_t snoop(operand_t op, cdb_t alu, cdb_t lsb);
        operand_t res;
        res = op;
        if (!op.rdy) begin
            if (alu.en && alu.rob_pos == op.rob) begin
                res.rdy = 1'b1;
                res.val = alu.val;
            end else if (lsb.en && lsb.rob_pos == op.rob) begin
                res.rdy = 1'b1;
                res.val = lsb.val;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/reservation_station_prio_enc.sv
// Lowest-set-bit priority encoder used for free-slot and ready-slot selection.
module reservation_station_prio_enc #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ID_W  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    output logic [ID_W-1:0]  idx_c,
    output logic             valid_c
);

    always_comb begin
        idx_c   = '0;
        valid_c = |req;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (req[i]) idx_c = ID_W'(i);
        end
    end

endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: holds dispatched ALU-class ops until both operands arrive, issues one ready op per cycle.
module reservation_station
    import reservation_station_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rollback,

    input  logic                 issue,
    input  logic [OPCODE_W-1:0]  issue_opcode,
    input  logic [FUNCT3_W-1:0]  issue_funct3,
    input  logic                 issue_funct7,
    input  logic                 issue_rs1_rdy,
    input  logic [DATA_W-1:0]    issue_rs1_val,
    input  logic [ROB_POS_W-1:0] issue_rs1_rob,
    input  logic                 issue_rs2_rdy,
    input  logic [DATA_W-1:0]    issue_rs2_val,
    input  logic [ROB_POS_W-1:0] issue_rs2_rob,
    input  logic [DATA_W-1:0]    issue_imm,
    input  logic [ADDR_W-1:0]    issue_pc,
    input  logic [ROB_POS_W-1:0] issue_rob_pos,
    output logic                 rs_full,

    input  logic                 alu_result,
    input  logic [ROB_POS_W-1:0] alu_result_rob_pos,
    input  logic [DATA_W-1:0]    alu_result_val,
    input  logic                 lsb_result,
    input  logic [ROB_POS_W-1:0] lsb_result_rob_pos,
    input  logic [DATA_W-1:0]    lsb_result_val,

    output logic                 alu_en,
    output logic [OPCODE_W-1:0]  alu_opcode,
    output logic [FUNCT3_W-1:0]  alu_funct3,
    output logic                 alu_funct7,
    output logic [DATA_W-1:0]    alu_val1,
    output logic [DATA_W-1:0]    alu_val2,
    output logic [DATA_W-1:0]    alu_imm,
    output logic [ADDR_W-1:0]    alu_pc,
    output logic [ROB_POS_W-1:0] alu_rob_pos
);

    rs_entry_t            ent_q [RS_SIZE];
    rs_entry_t            ent_d [RS_SIZE];
    rs_entry_t            new_ent;
    rs_entry_t            sel_ent;
    logic [RS_SIZE-1:0]   busy_vec;
    logic [RS_SIZE-1:0]   ready_vec;
    logic [RS_ID_W-1:0]   free_idx;
    logic [RS_ID_W-1:0]   sel_idx;
    logic                 free_valid;
    logic                 sel_valid;
    logic                 alloc;
    cdb_t                 alu_cdb;
    cdb_t                 lsb_cdb;

    assign alu_cdb = '{en: alu_result, rob_pos: alu_result_rob_pos, val: alu_result_val};
    assign lsb_cdb = '{en: lsb_result, rob_pos: lsb_result_rob_pos, val: lsb_result_val};

    reservation_station_prio_enc #(.WIDTH(RS_SIZE), .ID_W(RS_ID_W)) u_free_enc (
        .req     (~busy_vec),
        .idx_c   (free_idx),
        .valid_c (free_valid)
    );

    reservation_station_prio_enc #(.WIDTH(RS_SIZE), .ID_W(RS_ID_W)) u_ready_enc (
        .req     (ready_vec),
        .idx_c   (sel_idx),
        .valid_c (sel_valid)
    );

    assign rs_full = ~free_valid;
    assign alloc   = issue & free_valid;
    assign sel_ent = ent_q[sel_idx];

    // Incoming entry, with operands bypassed from a same-cycle broadcast.
    always_comb begin
        new_ent         = '0;
        new_ent.busy    = 1'b1;
        new_ent.opcode  = issue_opcode;
        new_ent.funct3  = issue_funct3;
        new_ent.funct7  = issue_funct7;
        new_ent.op1     = snoop('{rdy: issue_rs1_rdy, val: issue_rs1_val, rob: issue_rs1_rob}, alu_cdb, lsb_cdb);
        new_ent.op2     = snoop('{rdy: issue_rs2_rdy, val: issue_rs2_val, rob: issue_rs2_rob}, alu_cdb, lsb_cdb);
        new_ent.imm     = issue_imm;
        new_ent.pc      = issue_pc;
        new_ent.rob_pos = issue_rob_pos;
    end

    // Per-entry next state: wakeup, release on select, fill on alloc (slots never overlap).
    for (genvar g = 0; g < int'(RS_SIZE); g++) begin : g_entry
        rs_entry_t nxt;

        assign busy_vec[g]  = ent_q[g].busy;
        assign ready_vec[g] = ent_q[g].busy & ent_q[g].op1.rdy & ent_q[g].op2.rdy;

        always_comb begin
            nxt = ent_q[g];
            if (ent_q[g].busy) begin
                nxt.op1 = snoop(ent_q[g].op1, alu_cdb, lsb_cdb);
                nxt.op2 = snoop(ent_q[g].op2, alu_cdb, lsb_cdb);
            end
            if (sel_valid && sel_idx == RS_ID_W'(g)) nxt.busy = 1'b0;
            if (alloc && free_idx == RS_ID_W'(g)) nxt = new_ent;
        end

        assign ent_d[g] = nxt;
    end

    always_ff @(posedge clk) begin
        if (rst || rollback) begin
            for (int i = 0; i < int'(RS_SIZE); i++) ent_q[i] <= '0;
        end else if (rdy) begin
            for (int i = 0; i < int'(RS_SIZE); i++) ent_q[i] <= ent_d[i];
        end
    end

    // Registered issue port; operand fields hold when nothing is selected.
    always_ff @(posedge clk) begin
        if (rst || rollback) begin
            alu_en      <= 1'b0;
            alu_opcode  <= '0;
            alu_funct3  <= '0;
            alu_funct7  <= 1'b0;
            alu_val1    <= '0;
            alu_val2    <= '0;
            alu_imm     <= '0;
            alu_pc      <= '0;
            alu_rob_pos <= '0;
        end else if (rdy) begin
            alu_en <= sel_valid;
            if (sel_valid) begin
                alu_opcode  <= sel_ent.opcode;
                alu_funct3  <= sel_ent.funct3;
                alu_funct7  <= sel_ent.funct7;
                alu_val1    <= sel_ent.op1.val;
                alu_val2    <= sel_ent.op2.val;
                alu_imm     <= sel_ent.imm;
                alu_pc      <= sel_ent.pc;
                alu_rob_pos <= sel_ent.rob_pos;
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed and random stimulus for reservation_station, checked against a per-cycle behavioural model.
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback, issue;
    logic [6:0]  issue_opcode;
    logic [2:0]  issue_funct3;
    logic        issue_funct7;
    logic        issue_rs1_rdy, issue_rs2_rdy;
    logic [31:0] issue_rs1_val, issue_rs2_val, issue_imm, issue_pc;
    logic [3:0]  issue_rs1_rob, issue_rs2_rob, issue_rob_pos;
    logic        rs_full;
    logic        alu_result, lsb_result;
    logic [3:0]  alu_result_rob_pos, lsb_result_rob_pos;
    logic [31:0] alu_result_val, lsb_result_val;
    logic        alu_en, alu_funct7;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_funct3;
    logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
    logic [3:0]  alu_rob_pos;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reservation_station dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .issue(issue), .issue_opcode(issue_opcode), .issue_funct3(issue_funct3), .issue_funct7(issue_funct7),
        .issue_rs1_rdy(issue_rs1_rdy), .issue_rs1_val(issue_rs1_val), .issue_rs1_rob(issue_rs1_rob),
        .issue_rs2_rdy(issue_rs2_rdy), .issue_rs2_val(issue_rs2_val), .issue_rs2_rob(issue_rs2_rob),
        .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_rob_pos(issue_rob_pos), .rs_full(rs_full),
        .alu_result(alu_result), .alu_result_rob_pos(alu_result_rob_pos), .alu_result_val(alu_result_val),
        .lsb_result(lsb_result), .lsb_result_rob_pos(lsb_result_rob_pos), .lsb_result_val(lsb_result_val),
        .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
        .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos)
    );

    // Model: a slot table of waiting instructions plus the last thing handed to the ALU.
    typedef struct {
        bit          busy;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        bit          r1;
        logic [31:0] v1;
        logic [3:0]  q1;
        bit          r2;
        logic [31:0] v2;
        logic [3:0]  q2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  rob;
    } m_ent_t;

    m_ent_t      m [16];
    logic        e_en, e_f7;
    logic [6:0]  e_opc;
    logic [2:0]  e_f3;
    logic [31:0] e_v1, e_v2, e_imm, e_pc;
    logic [3:0]  e_rob;

    function automatic logic [32:0] listen(input bit r, input logic [31:0] v, input logic [3:0] q);
        if (r) return {1'b1, v};
        if (alu_result && alu_result_rob_pos == q) return {1'b1, alu_result_val};
        if (lsb_result && lsb_result_rob_pos == q) return {1'b1, lsb_result_val};
        return {1'b0, v};
    endfunction

    function automatic bit m_full();
        for (int i = 0; i < 16; i++) if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        int pick;
        int slot;
        bit full;
        if (rst || rollback) begin
            for (int i = 0; i < 16; i++) m[i].busy = 1'b0;
            {e_en, e_f7, e_opc, e_f3, e_v1, e_v2, e_imm, e_pc, e_rob} = '0;
            return;
        end
        if (!rdy) return;
        pick = -1;
        slot = -1;
        full = m_full();
        for (int i = 0; i < 16; i++) begin
            if (pick < 0 && m[i].busy && m[i].r1 && m[i].r2) pick = i;
            if (slot < 0 && !m[i].busy) slot = i;
        end
        e_en = (pick >= 0);
        if (pick >= 0) begin
            e_opc = m[pick].opc; e_f3 = m[pick].f3; e_f7 = m[pick].f7;
            e_v1 = m[pick].v1;   e_v2 = m[pick].v2; e_imm = m[pick].imm;
            e_pc = m[pick].pc;   e_rob = m[pick].rob;
            m[pick].busy = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            if (m[i].busy) begin
                {m[i].r1, m[i].v1} = listen(m[i].r1, m[i].v1, m[i].q1);
                {m[i].r2, m[i].v2} = listen(m[i].r2, m[i].v2, m[i].q2);
            end
        end
        if (issue && !full) begin
            m[slot].busy = 1'b1;
            m[slot].opc = issue_opcode; m[slot].f3 = issue_funct3; m[slot].f7 = issue_funct7;
            m[slot].q1 = issue_rs1_rob; m[slot].q2 = issue_rs2_rob;
            {m[slot].r1, m[slot].v1} = listen(issue_rs1_rdy, issue_rs1_val, issue_rs1_rob);
            {m[slot].r2, m[slot].v2} = listen(issue_rs2_rdy, issue_rs2_val, issue_rs2_rob);
            m[slot].imm = issue_imm; m[slot].pc = issue_pc; m[slot].rob = issue_rob_pos;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are already driven (just after a posedge); check, clock once, compare the ALU port.
    task automatic step();
        #1;
        check("rs_full", 32'(rs_full), 32'(m_full()));
        model_step();
        @(posedge clk);
        #1;
        check("alu_en", 32'(alu_en), 32'(e_en));
        check("alu_opcode", 32'(alu_opcode), 32'(e_opc));
        check("alu_funct3", 32'(alu_funct3), 32'(e_f3));
        check("alu_funct7", 32'(alu_funct7), 32'(e_f7));
        check("alu_val1", alu_val1, e_v1);
        check("alu_val2", alu_val2, e_v2);
        check("alu_imm", alu_imm, e_imm);
        check("alu_pc", alu_pc, e_pc);
        check("alu_rob_pos", 32'(alu_rob_pos), 32'(e_rob));
    endtask

    task automatic idle();
        rst = 1'b0; rdy = 1'b1; rollback = 1'b0; issue = 1'b0;
        alu_result = 1'b0; lsb_result = 1'b0;
    endtask

    task automatic put(input logic [6:0] op, input logic r1, input logic [31:0] v1, input logic [3:0] q1,
                       input logic r2, input logic [31:0] v2, input logic [3:0] q2, input logic [3:0] rob);
        issue = 1'b1; issue_opcode = op; issue_funct3 = 3'(rob); issue_funct7 = rob[0];
        issue_rs1_rdy = r1; issue_rs1_val = v1; issue_rs1_rob = q1;
        issue_rs2_rdy = r2; issue_rs2_val = v2; issue_rs2_rob = q2;
        issue_imm = 32'h100 + 32'(rob); issue_pc = 32'h8000 + {26'd0, rob, 2'b00}; issue_rob_pos = rob;
    endtask

    logic [6:0] ops [7];

    initial begin
        ops = '{OP_ARITH, OP_ARITHI, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        idle();
        put(OP_ARITH, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0, 4'd0);
        issue = 1'b0;
        rst = 1'b1;
        model_step();
        @(posedge clk);
        #1;
        step();
        idle();
        check("reset_alu_en", 32'(alu_en), 32'd0);
        check("reset_rs_full", 32'(rs_full), 32'd0);
        check("reset_alu_val1", alu_val1, 32'd0);

        // ADD with both operands ready issues two cycles later.
        put(OP_ARITH, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 4'd3);
        step();
        idle();
        step();
        check("t1_en", 32'(alu_en), 32'd1);
        check("t1_val1", alu_val1, 32'd5);
        check("t1_val2", alu_val2, 32'd7);
        check("t1_rob", 32'(alu_rob_pos), 32'd3);
        step();
        check("t1_freed", 32'(alu_en), 32'd0);

        // rs1 waits on rob 6, ALU broadcast wakes it.
        put(OP_ARITHI, 1'b0, 32'hDEAD, 4'd6, 1'b1, 32'd1, 4'd0, 4'd1);
        step();
        idle();
        alu_result = 1'b1; alu_result_rob_pos = 4'd6; alu_result_val = 32'h10;
        step();
        idle();
        check("t2_not_yet", 32'(alu_en), 32'd0);
        step();
        check("t2_en", 32'(alu_en), 32'd1);
        check("t2_val1", alu_val1, 32'h10);

        // Same-cycle LSB broadcast bypassed into a dispatching operand.
        put(OP_BR, 1'b1, 32'd9, 4'd0, 1'b0, 32'hBEEF, 4'd2, 4'd4);
        lsb_result = 1'b1; lsb_result_rob_pos = 4'd2; lsb_result_val = 32'hAB;
        step();
        idle();
        step();
        check("t3_en", 32'(alu_en), 32'd1);
        check("t3_val2", alu_val2, 32'hAB);

        // Fill all slots, overflow ignored, wake entry 0.
        for (int i = 0; i < 16; i++) begin
            put(OP_ARITH, 1'b0, 32'd0, 4'(i), 1'b1, 32'(i), 4'd0, 4'(i));
            step();
        end
        idle();
        check("t4_full", 32'(rs_full), 32'd1);
        put(OP_LUI, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0, 4'd15);
        step();
        idle();
        step();
        check("t4_ignored", 32'(alu_en), 32'd0);
        alu_result = 1'b1; alu_result_rob_pos = 4'd0; alu_result_val = 32'h55;
        step();
        idle();
        step();
        check("t4_en", 32'(alu_en), 32'd1);
        check("t4_val1", alu_val1, 32'h55);
        check("t4_rob", 32'(alu_rob_pos), 32'd0);
        check("t4_not_full", 32'(rs_full), 32'd0);
        rollback = 1'b1;
        step();
        idle();

        // Entries 4 and 9 ready together, then a rollback drops a later ready entry.
        for (int i = 0; i < 10; i++) begin
            put(OP_JALR, 1'b0, 32'd0, 4'(i), 1'b1, 32'd0, 4'd0, 4'(i));
            step();
        end
        idle();
        alu_result = 1'b1; alu_result_rob_pos = 4'd9; alu_result_val = 32'h99;
        lsb_result = 1'b1; lsb_result_rob_pos = 4'd4; lsb_result_val = 32'h44;
        step();
        idle();
        step();
        check("t5_first_rob", 32'(alu_rob_pos), 32'd4);
        check("t5_first_val", alu_val1, 32'h44);
        step();
        check("t5_second_rob", 32'(alu_rob_pos), 32'd9);
        check("t5_second_val", alu_val1, 32'h99);
        alu_result = 1'b1; alu_result_rob_pos = 4'd7; alu_result_val = 32'h77;
        step();
        idle();
        rollback = 1'b1;
        step();
        idle();
        check("t5_rollback_en", 32'(alu_en), 32'd0);
        step();
        check("t5_flushed", 32'(alu_en), 32'd0);

        // Freeze with rdy low around a pending issue, then resume.
        put(OP_AUIPC, 1'b0, 32'd0, 4'd8, 1'b1, 32'd3, 4'd0, 4'd8);
        step();
        idle();
        alu_result = 1'b1; alu_result_rob_pos = 4'd8; alu_result_val = 32'h88;
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            rdy = 1'b0;
            alu_result = 1'b1; alu_result_rob_pos = 4'd8; alu_result_val = 32'h1;
            step();
            check("t6_frozen", 32'(alu_en), 32'd0);
        end
        idle();
        step();
        check("t6_en", 32'(alu_en), 32'd1);
        check("t6_val1", alu_val1, 32'h88);
        rdy = 1'b0;
        step();
        check("t6_hold", 32'(alu_en), 32'd1);
        idle();
        step();
        check("t6_drop", 32'(alu_en), 32'd0);

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            idle();
            rdy      = ($urandom_range(9) != 0);
            rollback = ($urandom_range(59) == 0);
            if ($urandom_range(1) == 1) begin
                put(ops[$urandom_range(6)], ($urandom_range(2) != 0), $urandom, 4'($urandom_range(15)),
                    ($urandom_range(2) != 0), $urandom, 4'($urandom_range(15)), 4'($urandom_range(15)));
                issue_imm = $urandom;
                issue_pc  = $urandom;
            end
            alu_result         = ($urandom_range(2) == 0);
            alu_result_rob_pos = 4'($urandom_range(15));
            alu_result_val     = $urandom;
            lsb_result         = ($urandom_range(2) == 0);
            lsb_result_rob_pos = alu_result_rob_pos ^ 4'($urandom_range(14) + 1);
            lsb_result_val     = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
